// File: rtl/imm_gen_pkg.sv
// Shared opcodes, immediate format codes and a sign-extension helper
// for the RISC-V immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    // Sign-extend v to 64 bits, treating bit msb as the sign bit.
    function automatic logic [63:0] sext(input logic [31:0] v, input int msb);
        logic [63:0] r;
        for (int i = 0; i < 64; i++)
            r[i] = (i <= msb) ? v[i[4:0]] : v[msb[4:0]];
        return r;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Pure combinational instruction -> {immediate, format, illegal} decoder.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]  opc;
    logic        is_shift;
    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [63:0] imm64;
    logic        unused_hi;

    assign opc      = instr[6:0];
    // funct3 001 (SLL) and 101 (SRL/SRA) carry a shift amount, not an I imm
    assign is_shift = (instr[13:12] == 2'b01);

    assign i_imm = sext({20'b0, instr[31:20]}, 11);
    assign s_imm = sext({20'b0, instr[31:25], instr[11:7]}, 11);
    assign b_imm = sext({19'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 12);
    assign u_imm = sext({instr[31:12], 12'b0}, 31);
    assign j_imm = sext({11'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 20);

    // Select immediate and format by opcode; unknown opcodes flag illegal
    always_comb begin
        imm64   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm64 = i_imm;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    fmt   = FMT_SHAMT;
                    // bit 30 selects SRA vs SRL and is never part of the amount
                    imm64 = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
                end else begin
                    fmt   = FMT_I;
                    imm64 = i_imm;
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    fmt   = FMT_SHAMT;
                    imm64 = {59'b0, instr[24:20]};
                end else begin
                    fmt   = FMT_I;
                    imm64 = i_imm;
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm64 = s_imm;
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm64 = b_imm;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm64 = u_imm;
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm64 = j_imm;
            end
            OPC_OP, OPC_FENCE, OPC_SYSTEM: ;
            OPC_OP_32: illegal = (XLEN != 64);
            default:   illegal = 1'b1;
        endcase
    end

    assign imm       = imm64[XLEN-1:0];
    assign unused_hi = ^imm64;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode registered into a two-entry
// (main + skid) buffer with valid/ready handshake on both sides.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t     dec_q, main_q, skid_q;
    logic     main_vld, skid_vld;
    logic     in_xfer, out_xfer;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (dec_q.imm),
        .fmt     (dec_q.fmt),
        .illegal (dec_q.illegal)
    );
    assign dec_q.tag = in_tag;

    // in_ready comes straight off the skid flag, so no path from out_ready
    assign in_ready = !skid_vld;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_vld && out_ready;

    // Main/skid buffer update: skid only fills while main is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (!main_vld) begin
            if (in_xfer) begin
                main_vld <= 1'b1;
                main_q   <= dec_q;
            end
        end else if (out_xfer) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (in_xfer) begin
                main_q   <= dec_q;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_vld <= 1'b1;
            skid_q   <= dec_q;
        end
    end

    assign out_valid   = main_vld;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule
